// File: rtl/audio_mixer_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : audio_mixer_pkg                                                |
// | Purpose  : Shared constants, register map and FSM state type for the      |
// |            audio mixer block.                                             |
// | Revision : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
package audio_mixer_pkg;

    localparam int MIXER_ADDR_WIDTH = 2;

    localparam logic [MIXER_ADDR_WIDTH-1:0] MIXER_REG_SID_GAIN    = 2'd0;
    localparam logic [MIXER_ADDR_WIDTH-1:0] MIXER_REG_CB2_GAIN    = 2'd1;
    localparam logic [MIXER_ADDR_WIDTH-1:0] MIXER_REG_MASTER_GAIN = 2'd2;
    localparam logic [MIXER_ADDR_WIDTH-1:0] MIXER_REG_CTRL        = 2'd3;

    // Q1.7 gain of exactly 1.0
    localparam logic [7:0] Q17_UNITY = 8'h80;

    // ST_DCB is only visited when the DC-block filter is compiled in.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_MUL_SID = 3'd1,
        ST_MUL_CB2 = 3'd2,
        ST_SUM     = 3'd3,
        ST_DCB     = 3'd4,
        ST_MASTER  = 3'd5,
        ST_OUT     = 3'd6
    } mixer_state_t;

endpackage
`default_nettype wire

// File: rtl/audio_mixer_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : audio_mixer_if                                                 |
// | Purpose  : CPU register-window bus of the audio mixer.                    |
// |            master = CPU side, slave = mixer side.                         |
// | Signals  : mixer_en_i window select, cpu_wr_en_i write strobe,            |
// |            addr_i register address, data_i write data,                    |
// |            data_o read data (combinational on addr_i).                    |
// | Revision : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
interface audio_mixer_if;
    import audio_mixer_pkg::*;

    logic                        mixer_en_i;
    logic                        cpu_wr_en_i;
    logic [MIXER_ADDR_WIDTH-1:0] addr_i;
    logic [7:0]                  data_i;
    logic [7:0]                  data_o;

    modport master (output mixer_en_i, cpu_wr_en_i, addr_i, data_i, input data_o);
    modport slave  (input mixer_en_i, cpu_wr_en_i, addr_i, data_i, output data_o);

endinterface
`default_nettype wire

// File: rtl/audio_mixer_sat.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : audio_sat                                                      |
// | Purpose  : Saturate a signed IN_W-bit value (IN_W > 16) to signed 16 bit. |
// | Ports    : i_din  signed input, o_dout saturated result,                  |
// |            o_ovf  high when clamping took place.                          |
// | Revision : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module audio_sat #(
    parameter int IN_W = 19
) (
    input  logic signed [IN_W-1:0] i_din,
    output logic signed [15:0]     o_dout,
    output logic                   o_ovf
);
    // Value fits in 16 bits only when every bit from 15 upward matches the sign.
    logic [IN_W-16:0] w_hi;

    assign w_hi   = i_din[IN_W-1:15];
    assign o_ovf  = ~((&w_hi) | ~(|w_hi));
    assign o_dout = o_ovf ? (i_din[IN_W-1] ? 16'sh8000 : 16'sh7FFF) : i_din[15:0];

endmodule
`default_nettype wire

// File: rtl/audio_mixer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : audio_mixer                                                    |
// | Purpose  : Mixes the SID sample with the VIA CB2 beeper level, applies    |
// |            per-source and master Q1.7 gains with saturation and feeds     |
// |            the 16-bit delta-sigma DAC. One multiplier is time-shared by   |
// |            a sequencing FSM; CB2 edges can be slewed to avoid clicks.     |
// | Ports    : sys_clock_i, reset_i (sync, active high), sample_en_i strobe,  |
// |            sid_i, via_cb2_i, diag_i, bus (CPU register window),           |
// |            mix_o signed sample, mix_valid_o one-cycle update pulse.       |
// | Options  : AUDIO_MIXER_DC_BLOCK_EN adds a DC-block stage (latency 6).     |
// | Revision : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module audio_mixer
    import audio_mixer_pkg::*;
#(
    parameter logic [15:0] RAMP_STEP = 16'h0040,
    parameter logic [15:0] CB2_LEVEL = 16'h0800
`ifdef AUDIO_MIXER_DC_BLOCK_EN
    ,
    parameter int DC_SHIFT = 8
`endif
) (
    input  logic               sys_clock_i,
    input  logic               reset_i,
    input  logic               sample_en_i,
    input  logic signed [15:0] sid_i,
    input  logic               via_cb2_i,
    input  logic               diag_i,
    audio_mixer_if.slave       bus,
    output logic signed [15:0] mix_o,
    output logic               mix_valid_o
);
    localparam logic signed [15:0] c_lvl_pos = $signed(CB2_LEVEL);
    localparam logic signed [15:0] c_lvl_neg = -c_lvl_pos;
    localparam logic signed [15:0] c_step    = $signed(RAMP_STEP);

    mixer_state_t       r_state, w_state_next;
    logic [7:0]         r_sid_gain, r_cb2_gain, r_master_gain;
    logic               r_mute, r_ramp_en, r_clip;
    logic signed [15:0] r_sid, r_cb2_lvl, w_cb2_next, r_acc, r_master;
    logic               r_cb2_tgt;
    logic signed [17:0] r_sid_scaled, r_cb2_scaled, w_scaled;
    logic signed [18:0] w_sum;
    logic signed [15:0] w_sum_sat, w_mst_sat, w_mst_in, w_mul_a;
    logic               w_sum_ovf, w_mst_ovf, w_clip_set, w_wr;
    logic [7:0]         w_mul_g;
    logic signed [24:0] w_prod;

    assign w_wr = bus.mixer_en_i & bus.cpu_wr_en_i;

    // ---------------- register window ----------------
    always_comb begin
        bus.data_o = 8'h00;
        case (bus.addr_i)
            MIXER_REG_SID_GAIN:    bus.data_o = r_sid_gain;
            MIXER_REG_CB2_GAIN:    bus.data_o = r_cb2_gain;
            MIXER_REG_MASTER_GAIN: bus.data_o = r_master_gain;
            default:               bus.data_o = {r_clip, 5'b0, r_ramp_en, r_mute};
        endcase
    end

    always_ff @(posedge sys_clock_i) begin
        if (reset_i) begin
            r_sid_gain    <= Q17_UNITY;
            r_cb2_gain    <= Q17_UNITY;
            r_master_gain <= Q17_UNITY;
            r_mute        <= 1'b0;
            r_ramp_en     <= 1'b0;
            r_clip        <= 1'b0;
        end else begin
            if (w_wr) begin
                case (bus.addr_i)
                    MIXER_REG_SID_GAIN:    r_sid_gain    <= bus.data_i;
                    MIXER_REG_CB2_GAIN:    r_cb2_gain    <= bus.data_i;
                    MIXER_REG_MASTER_GAIN: r_master_gain <= bus.data_i;
                    default: begin
                        r_mute    <= bus.data_i[0];
                        r_ramp_en <= bus.data_i[1];
                        r_clip    <= 1'b0;
                    end
                endcase
            end
            // A saturation in the same cycle as a CTRL write must win.
            if (w_clip_set) r_clip <= 1'b1;
        end
    end

    // ---------------- CB2 level slew ----------------
    always_comb begin
        logic signed [15:0] v_tgt;
        v_tgt      = r_cb2_tgt ? c_lvl_pos : c_lvl_neg;
        w_cb2_next = v_tgt;
        if (r_ramp_en) begin
            if (r_cb2_lvl < v_tgt)
                w_cb2_next = (r_cb2_lvl + c_step > v_tgt) ? v_tgt : r_cb2_lvl + c_step;
            else if (r_cb2_lvl > v_tgt)
                w_cb2_next = (r_cb2_lvl - c_step < v_tgt) ? v_tgt : r_cb2_lvl - c_step;
        end
    end

    // ---------------- shared multiplier ----------------
    always_comb begin
        w_mul_a = r_sid;
        w_mul_g = r_sid_gain;
        case (r_state)
            ST_MUL_CB2: begin w_mul_a = w_cb2_next; w_mul_g = r_cb2_gain;    end
            ST_MASTER:  begin w_mul_a = w_mst_in;   w_mul_g = r_master_gain; end
            default:    ;
        endcase
    end

    // Gain is unsigned, so it is zero-extended before the signed multiply.
    assign w_prod   = 25'(w_mul_a) * 25'($signed({1'b0, w_mul_g}));
    assign w_scaled = 18'(w_prod >>> 7);
    assign w_sum    = 19'(r_sid_scaled) + 19'(r_cb2_scaled);

    audio_sat #(.IN_W(19)) u_sat_sum (.i_din(w_sum),    .o_dout(w_sum_sat), .o_ovf(w_sum_ovf));
    audio_sat #(.IN_W(18)) u_sat_mst (.i_din(w_scaled), .o_dout(w_mst_sat), .o_ovf(w_mst_ovf));

`ifdef AUDIO_MIXER_DC_BLOCK_EN
    logic signed [15:0] r_xp, r_yp, w_dcb_sat;
    logic signed [17:0] w_dcb;
    logic               w_dcb_ovf;

    assign w_dcb = 18'(r_acc) - 18'(r_xp) + 18'(r_yp) - 18'(r_yp >>> DC_SHIFT);

    audio_sat #(.IN_W(18)) u_sat_dcb (.i_din(w_dcb), .o_dout(w_dcb_sat), .o_ovf(w_dcb_ovf));

    assign w_mst_in   = r_yp;
    assign w_clip_set = ((r_state == ST_SUM)    & w_sum_ovf) |
                        ((r_state == ST_DCB)    & w_dcb_ovf) |
                        ((r_state == ST_MASTER) & w_mst_ovf);
`else
    assign w_mst_in   = r_acc;
    assign w_clip_set = ((r_state == ST_SUM)    & w_sum_ovf) |
                        ((r_state == ST_MASTER) & w_mst_ovf);
`endif

    // ---------------- sequencer ----------------
    always_ff @(posedge sys_clock_i) begin
        if (reset_i) r_state <= ST_IDLE;
        else         r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = ST_IDLE;
        case (r_state)
            ST_IDLE:    w_state_next = sample_en_i ? ST_MUL_SID : ST_IDLE;
            ST_MUL_SID: w_state_next = ST_MUL_CB2;
            ST_MUL_CB2: w_state_next = ST_SUM;
`ifdef AUDIO_MIXER_DC_BLOCK_EN
            ST_SUM:     w_state_next = ST_DCB;
            ST_DCB:     w_state_next = ST_MASTER;
`else
            ST_SUM:     w_state_next = ST_MASTER;
`endif
            ST_MASTER:  w_state_next = ST_OUT;
            default:    w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge sys_clock_i) begin
        if (reset_i) begin
            r_sid        <= '0;
            r_cb2_tgt    <= 1'b0;
            r_cb2_lvl    <= c_lvl_neg;
            r_sid_scaled <= '0;
            r_cb2_scaled <= '0;
            r_acc        <= '0;
            r_master     <= '0;
            mix_o        <= '0;
            mix_valid_o  <= 1'b0;
`ifdef AUDIO_MIXER_DC_BLOCK_EN
            r_xp         <= '0;
            r_yp         <= '0;
`endif
        end else begin
            mix_valid_o <= 1'b0;
            case (r_state)
                ST_IDLE: if (sample_en_i) begin
                    r_sid     <= sid_i;
                    r_cb2_tgt <= via_cb2_i & diag_i;
                end
                ST_MUL_SID: r_sid_scaled <= w_scaled;
                ST_MUL_CB2: begin
                    r_cb2_lvl    <= w_cb2_next;
                    r_cb2_scaled <= w_scaled;
                end
                ST_SUM: r_acc <= w_sum_sat;
`ifdef AUDIO_MIXER_DC_BLOCK_EN
                ST_DCB: begin
                    r_xp <= r_acc;
                    r_yp <= w_dcb_sat;
                end
`endif
                ST_MASTER: r_master <= w_mst_sat;
                ST_OUT: begin
                    mix_o       <= r_mute ? 16'sh0000 : r_master;
                    mix_valid_o <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_audio_mixer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_audio_mixer                                                 |
// | Purpose  : Self-checking bench for audio_mixer: register reset values,    |
// |            mixing vectors, saturation/CLIP, mute, CB2 ramp, dropped       |
// |            strobes and mid-sequence reset.                                |
// | Revision : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module tb_audio_mixer;
    import audio_mixer_pkg::*;

`ifdef AUDIO_MIXER_DC_BLOCK_EN
    localparam int LAT = 6;
`else
    localparam int LAT = 5;
`endif

    logic               clk = 1'b0;
    logic               rst;
    logic               sample_en;
    logic [15:0]        sid;
    logic               via_cb2;
    logic               diag;
    logic signed [15:0] mix;
    logic               mix_valid;

    audio_mixer_if bus ();

    audio_mixer dut (
        .sys_clock_i (clk),
        .reset_i     (rst),
        .sample_en_i (sample_en),
        .sid_i       (sid),
        .via_cb2_i   (via_cb2),
        .diag_i      (diag),
        .bus         (bus),
        .mix_o       (mix),
        .mix_valid_o (mix_valid)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int pulses   = 0;

    always @(negedge clk) if (mix_valid) pulses++;

    typedef struct {
        logic [15:0] sid;
        logic        cb2;
        logic        diag;
        logic [7:0]  g_sid;
        logic [7:0]  g_cb2;
        logic [7:0]  g_mst;
        logic [7:0]  ctrl;
        logic [15:0] exp_mix;
        logic [7:0]  exp_ctrl;
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%04h expected 0x%04h", name, act, exp);
        end
    endtask

    // All tasks start and end at 1 time unit after a rising edge.
    task automatic write_reg(input logic [1:0] a, input logic [7:0] d);
        bus.mixer_en_i  = 1'b1;
        bus.cpu_wr_en_i = 1'b1;
        bus.addr_i      = a;
        bus.data_i      = d;
        @(posedge clk); #1;
        bus.mixer_en_i  = 1'b0;
        bus.cpu_wr_en_i = 1'b0;
    endtask

    task automatic read_reg(input logic [1:0] a, output logic [7:0] d);
        bus.addr_i = a;
        #1;
        d = bus.data_o;
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (!mix_valid && lat < 12) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic run_sample(input logic [15:0] s, input logic c, input logic dg,
                              input logic [15:0] exp, input string name);
        int lat;
        sid       = s;
        via_cb2   = c;
        diag      = dg;
        sample_en = 1'b1;
        @(posedge clk); #1;
        sample_en = 1'b0;
        wait_valid(lat);
        check({name, "_latency"}, 16'(lat), 16'(LAT));
        check(name, mix, exp);
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] rd;
        int         lat;
        int         p0;
        int         e;

        //            sid       cb2   diag  gsid   gcb2   gmst   ctrl   exp_mix    exp_ctrl
        vecs[0]  = '{16'h1000, 1'b0, 1'b0, 8'h80, 8'h80, 8'h80, 8'h00, 16'h0800, 8'h00};
        vecs[1]  = '{16'h7000, 1'b1, 1'b1, 8'hFF, 8'h80, 8'h80, 8'h00, 16'h7FFF, 8'h80};
        vecs[2]  = '{16'h4000, 1'b1, 1'b0, 8'h80, 8'h80, 8'h80, 8'h00, 16'h3800, 8'h00};
        vecs[3]  = '{16'h1000, 1'b1, 1'b1, 8'h80, 8'h80, 8'h80, 8'h00, 16'h1800, 8'h00};
        vecs[4]  = '{16'h1000, 1'b0, 1'b0, 8'h80, 8'h80, 8'h40, 8'h00, 16'h0400, 8'h00};
        vecs[5]  = '{16'h8000, 1'b0, 1'b0, 8'h80, 8'h80, 8'h80, 8'h00, 16'h8000, 8'h80};
        vecs[6]  = '{16'h6000, 1'b0, 1'b0, 8'h80, 8'h80, 8'hFF, 8'h00, 16'h7FFF, 8'h80};
        vecs[7]  = '{16'h1234, 1'b0, 1'b0, 8'h80, 8'h00, 8'h80, 8'h00, 16'h1234, 8'h00};
        vecs[8]  = '{16'h2000, 1'b1, 1'b1, 8'h40, 8'h40, 8'h80, 8'h00, 16'h1400, 8'h00};
        vecs[9]  = '{16'h4000, 1'b0, 1'b0, 8'h80, 8'h80, 8'h80, 8'h01, 16'h0000, 8'h01};
        vecs[10] = '{16'h7000, 1'b1, 1'b1, 8'hFF, 8'h80, 8'h80, 8'h01, 16'h0000, 8'h81};
        vecs[11] = '{16'hFFFF, 1'b0, 1'b0, 8'h40, 8'h00, 8'h80, 8'h00, 16'hFFFF, 8'h00};
        vecs[12] = '{16'h0003, 1'b0, 1'b0, 8'h40, 8'h00, 8'h80, 8'h00, 16'h0001, 8'h00};

        rst             = 1'b1;
        sample_en       = 1'b0;
        sid             = '0;
        via_cb2         = 1'b0;
        diag            = 1'b0;
        bus.mixer_en_i  = 1'b0;
        bus.cpu_wr_en_i = 1'b0;
        bus.addr_i      = '0;
        bus.data_i      = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        for (int a = 0; a < 4; a++) begin
            read_reg(2'(a), rd);
            check($sformatf("reset_reg%0d", a), 16'(rd), (a == 3) ? 16'h0000 : 16'h0080);
        end
        check("reset_mix", mix, 16'h0000);
        repeat (4) @(posedge clk);
        #1;
        check("reset_no_pulse", 16'(pulses), 16'd0);

        // Table-driven mixing vectors
        for (int i = 0; i < 13; i++) begin
            write_reg(MIXER_REG_SID_GAIN,    vecs[i].g_sid);
            write_reg(MIXER_REG_CB2_GAIN,    vecs[i].g_cb2);
            write_reg(MIXER_REG_MASTER_GAIN, vecs[i].g_mst);
            write_reg(MIXER_REG_CTRL,        vecs[i].ctrl);
            run_sample(vecs[i].sid, vecs[i].cb2, vecs[i].diag, vecs[i].exp_mix,
                       $sformatf("vec%0d_mix", i));
            read_reg(MIXER_REG_CTRL, rd);
            check($sformatf("vec%0d_ctrl", i), 16'(rd), 16'(vecs[i].exp_ctrl));
        end

        // CTRL write coinciding with the SUM saturation keeps CLIP set
        write_reg(MIXER_REG_SID_GAIN, 8'hFF);
        write_reg(MIXER_REG_CB2_GAIN, 8'h80);
        write_reg(MIXER_REG_CTRL, 8'h00);
        sid = 16'h7000; via_cb2 = 1'b1; diag = 1'b1; sample_en = 1'b1;
        @(posedge clk); #1;
        sample_en = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        write_reg(MIXER_REG_CTRL, 8'h00);
        wait_valid(lat);
        check("collide_mix", mix, 16'h7FFF);
        read_reg(MIXER_REG_CTRL, rd);
        check("collide_clip_kept", 16'(rd), 16'h0080);
        write_reg(MIXER_REG_CTRL, 8'h00);
        read_reg(MIXER_REG_CTRL, rd);
        check("clip_cleared", 16'(rd), 16'h0000);
        write_reg(MIXER_REG_SID_GAIN, 8'h80);
        repeat (3) @(posedge clk);
        #1;

        // Strobe 3 clocks after the first is dropped
        p0 = pulses;
        sid = 16'h1000; via_cb2 = 1'b0; diag = 1'b0; sample_en = 1'b1;
        @(posedge clk); #1;
        sample_en = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        sid = 16'h2000; sample_en = 1'b1;
        @(posedge clk); #1;
        sample_en = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        check("drop_pulses", 16'(pulses - p0), 16'd1);
        check("drop_mix", mix, 16'h0800);

        // Reset 2 clocks after the strobe aborts the sample
        write_reg(MIXER_REG_SID_GAIN, 8'h40);
        p0 = pulses;
        sid = 16'h4000; sample_en = 1'b1;
        @(posedge clk); #1;
        sample_en = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("abort_pulses", 16'(pulses - p0), 16'd0);
        check("abort_mix", mix, 16'h0000);
        read_reg(MIXER_REG_SID_GAIN, rd);
        check("abort_gain_reset", 16'(rd), 16'h0080);

        // CB2 ramp from the reset level up to +full scale, then back down
        write_reg(MIXER_REG_CTRL, 8'h02);
        for (int k = 1; k <= 66; k++) begin
            e = -2048 + 64 * k;
            if (e > 2048) e = 2048;
            run_sample(16'h0000, 1'b1, 1'b1, 16'(e), $sformatf("ramp_up%0d", k));
        end
        for (int k = 1; k <= 3; k++) begin
            run_sample(16'h0000, 1'b0, 1'b1, 16'(2048 - 64 * k), $sformatf("ramp_dn%0d", k));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
